aes_leak_monitor: RTL and testbench

Parametrised runtime leakage monitor for the AES key-register path. Tracks NumWords key-share word pairs, evaluates a Hamming-weight plus key-stability trigger condition per word, and checks a suspect probe net against the selected unmasked key bit. It raises a sticky alert once the probe has matched for MatchThresh consecutive valid samples. It sits beside aes_core in the trojan-detection build, driven by the same key-share write strobes. It generalises the single-word, single-bit HW/stability check to N words, a configurable HW source and a correlation counter.

---
 rtl/aes_leak_monitor.sv | 225 ++++++++++++++++++++++
 tb/tb_aes_leak_monitor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_leak_monitor.sv
// ---------------------------------------------------------------------------
// aes_leak_monitor
//
// Runtime leakage monitor for the AES key-register path. Keeps a private copy
// of NumWords key-share word pairs, flags a word as "triggered" once its
// Hamming weight reaches HwThresh and it has been left unwritten for
// StableCycles edges. While triggered, a suspect probe net is compared with
// bit ProbeBit of the lowest triggered unmasked word. MatchThresh consecutive
// valid matches raise a sticky alert and latch the offending word index.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   cfg_en_i       monitor enable
//   clear_i        clears alert, match count and latched word index
//   key_we_i       per-word key-share write strobe
//   key_share0_i   share0 words, word w at [w*Width +: Width]
//   key_share1_i   share1 words, same packing
//   probe_i        suspect net under test
//   probe_valid_i  probe_i sample qualifier
//   trig_o         per-word trigger condition met
//   match_cnt_o    current consecutive-match count
//   leak_alert_o   sticky leakage alert
//   leak_word_o    word index latched when the alert fired
// ---------------------------------------------------------------------------
module aes_leak_monitor #(
  parameter int NumWords     = 4,
  parameter int Width        = 32,
  parameter int HwThresh     = 24,
  parameter int StableCycles = 4,
  parameter int HwMode       = 0,
  parameter int ProbeBit     = 0,
  parameter int MatchThresh  = 8,
  parameter int CntW         = $clog2(MatchThresh + 1),
  localparam int IdxW        = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cfg_en_i,
  input  logic                      clear_i,
  input  logic [NumWords-1:0]       key_we_i,
  input  logic [NumWords*Width-1:0] key_share0_i,
  input  logic [NumWords*Width-1:0] key_share1_i,
  input  logic                      probe_i,
  input  logic                      probe_valid_i,
  output logic [NumWords-1:0]       trig_o,
  output logic [CntW-1:0]           match_cnt_o,
  output logic                      leak_alert_o,
  output logic [IdxW-1:0]           leak_word_o
);

  localparam int HwW   = $clog2(Width + 1);
  localparam int StabW = $clog2(StableCycles + 1);

  localparam logic [HwW-1:0]   HW_TH    = HwW'(HwThresh);
  localparam logic [StabW-1:0] STAB_MAX = StabW'(StableCycles);
  localparam logic [CntW-1:0]  CNT_MAX  = CntW'(MatchThresh);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    ALERT   = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------
  function automatic logic [HwW-1:0] popcount(input logic [Width-1:0] v);
    logic [HwW-1:0] acc;
    acc = '0;
    for (int i = 0; i < Width; i++) begin
      acc = acc + HwW'(v[i]);
    end
    return acc;
  endfunction

  function automatic logic [CntW-1:0] sat_inc_cnt(input logic [CntW-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  function automatic logic [StabW-1:0] sat_inc_stab(input logic [StabW-1:0] v);
    return (v >= STAB_MAX) ? STAB_MAX : v + 1'b1;
  endfunction

  // -------------------------------------------------------------------------
  // Stage 0: key-share shadow registers and per-word stability counters.
  // These run in every FSM state so stability is already known when the
  // monitor is (re-)enabled.
  // -------------------------------------------------------------------------
  logic [Width-1:0] s0_q   [NumWords];
  logic [Width-1:0] s1_q   [NumWords];
  logic [StabW-1:0] stab_q [NumWords];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < NumWords; w++) begin
        s0_q[w]   <= '0;
        s1_q[w]   <= '0;
        stab_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NumWords; w++) begin
        if (key_we_i[w]) begin
          // Any write, even of identical data, restarts the stability window.
          s0_q[w]   <= key_share0_i[w*Width +: Width];
          s1_q[w]   <= key_share1_i[w*Width +: Width];
          stab_q[w] <= '0;
        end else begin
          stab_q[w] <= sat_inc_stab(stab_q[w]);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: combinational trigger evaluation and lowest-index selection,
  // all from registered values so a write on a sample edge does not affect
  // that edge's comparison.
  // -------------------------------------------------------------------------
  state_e state_q, state_d;

  logic [Width-1:0]    unm     [NumWords];
  logic [NumWords-1:0] trig;
  logic                any_trig;
  logic [IdxW-1:0]     sel;
  logic                exp_bit;

  always_comb begin
    trig = '0;
    for (int w = 0; w < NumWords; w++) begin
      unm[w]  = s0_q[w] ^ s1_q[w];
      trig[w] = (popcount((HwMode != 0) ? unm[w] : s0_q[w]) >= HW_TH) &&
                (stab_q[w] == STAB_MAX) &&
                (state_q != IDLE);
    end
  end

  always_comb begin
    sel     = '0;
    exp_bit = 1'b0;
    // Walk from the top down so the lowest triggered index is the last write.
    for (int w = NumWords - 1; w >= 0; w--) begin
      if (trig[w]) begin
        sel     = IdxW'(w);
        exp_bit = unm[w][ProbeBit];
      end
    end
  end

  assign any_trig = |trig;

  // -------------------------------------------------------------------------
  // Stage 2: correlation FSM, match counter and sticky alert.
  // -------------------------------------------------------------------------
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            alert_q, alert_d;
  logic [IdxW-1:0] word_q, word_d;
  logic [CntW-1:0] cnt_inc;

  assign cnt_inc = sat_inc_cnt(cnt_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      alert_q <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alert_q <= alert_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    alert_d = alert_q;
    word_d  = word_q;

    if (clear_i) begin
      // Clear outranks any match or alert decided on the same edge.
      cnt_d   = '0;
      alert_d = 1'b0;
      word_d  = '0;
      state_d = cfg_en_i ? MONITOR : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_en_i) state_d = MONITOR;
        end
        MONITOR: begin
          if (!cfg_en_i) begin
            // Leaving keeps the count; the probe is not sampled on this edge.
            state_d = IDLE;
          end else if (probe_valid_i) begin
            if (!any_trig) begin
              cnt_d = '0;
            end else if (probe_i == exp_bit) begin
              cnt_d = cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                state_d = ALERT;
                alert_d = 1'b1;
                word_d  = sel;
              end
            end else begin
              cnt_d = '0;
            end
          end
        end
        ALERT: begin
          // Sticky: only clear_i leaves this state.
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign trig_o       = trig;
  assign match_cnt_o  = cnt_q;
  assign leak_alert_o = alert_q;
  assign leak_word_o  = word_q;

endmodule

// File: tb/tb_aes_leak_monitor.sv
// ---------------------------------------------------------------------------
// tb_aes_leak_monitor
//
// Drives two monitors (HwMode 0 and HwMode 1) from the same stimulus and
// compares them each cycle with a cycle-count based reference model: a word
// is stable when at least StableCycles edges have passed since its last
// write, and the monitor is a simple enable/alert bookkeeping of matches.
// ---------------------------------------------------------------------------
module tb_aes_leak_monitor;

  localparam int NW = 4;
  localparam int W  = 32;
  localparam int HT = 24;
  localparam int ST = 4;
  localparam int MT = 8;

  localparam int M_IDLE  = 0;
  localparam int M_MON   = 1;
  localparam int M_ALERT = 2;

  logic            clk;
  logic            rst_ni;
  logic            cfg_en;
  logic            clear;
  logic [NW-1:0]   key_we;
  logic [NW*W-1:0] sh0;
  logic [NW*W-1:0] sh1;
  logic            probe;
  logic            probe_valid;

  logic [NW-1:0] trig0, trig1;
  logic [3:0]    cnt0, cnt1;
  logic          al0, al1;
  logic [1:0]    wd0, wd1;

  aes_leak_monitor #(.HwMode(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_en_i(cfg_en), .clear_i(clear),
    .key_we_i(key_we), .key_share0_i(sh0), .key_share1_i(sh1),
    .probe_i(probe), .probe_valid_i(probe_valid),
    .trig_o(trig0), .match_cnt_o(cnt0), .leak_alert_o(al0), .leak_word_o(wd0)
  );

  aes_leak_monitor #(.HwMode(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_en_i(cfg_en), .clear_i(clear),
    .key_we_i(key_we), .key_share0_i(sh0), .key_share1_i(sh1),
    .probe_i(probe), .probe_valid_i(probe_valid),
    .trig_o(trig1), .match_cnt_o(cnt1), .leak_alert_o(al1), .leak_word_o(wd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] ms0 [NW];
  logic [W-1:0] ms1 [NW];
  int           wcyc [NW];
  int           cyc;
  int           mst  [2];
  int           mcnt [2];
  int           mal  [2];
  int           mwd  [2];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] mtrig(input int m);
    logic [NW-1:0] t;
    logic [W-1:0]  src;
    t = '0;
    for (int w = 0; w < NW; w++) begin
      src = (m == 1) ? (ms0[w] ^ ms1[w]) : ms0[w];
      if ($countones(src) >= HT && (cyc - wcyc[w]) >= ST && mst[m] != M_IDLE)
        t[w] = 1'b1;
    end
    return t;
  endfunction

  function automatic void model_reset();
    for (int w = 0; w < NW; w++) begin
      ms0[w]  = '0;
      ms1[w]  = '0;
      wcyc[w] = cyc;
    end
    for (int m = 0; m < 2; m++) begin
      mst[m] = M_IDLE; mcnt[m] = 0; mal[m] = 0; mwd[m] = 0;
    end
  endfunction

  // Advance the model by one clock edge using the inputs present at it.
  function automatic void model_edge();
    logic [NW-1:0] t;
    logic [W-1:0]  u;
    int            s;
    if (!rst_ni) begin
      cyc++;
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      t = mtrig(m);
      s = -1;
      for (int w = 0; w < NW; w++) if (t[w] && s < 0) s = w;
      if (s < 0) u = '0; else u = ms0[s] ^ ms1[s];
      if (clear) begin
        mcnt[m] = 0; mal[m] = 0; mwd[m] = 0;
        mst[m] = cfg_en ? M_MON : M_IDLE;
      end else if (mst[m] == M_IDLE) begin
        if (cfg_en) mst[m] = M_MON;
      end else if (mst[m] == M_MON) begin
        if (!cfg_en) mst[m] = M_IDLE;
        else if (probe_valid) begin
          if (s < 0 || probe !== u[0]) mcnt[m] = 0;
          else begin
            mcnt[m] = (mcnt[m] + 1 > MT) ? MT : mcnt[m] + 1;
            if (mcnt[m] == MT) begin
              mst[m] = M_ALERT; mal[m] = 1; mwd[m] = s;
            end
          end
        end
      end
    end
    cyc++;
    for (int w = 0; w < NW; w++) begin
      if (key_we[w]) begin
        ms0[w]  = sh0[w*W +: W];
        ms1[w]  = sh1[w*W +: W];
        wcyc[w] = cyc;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".trig0"}, 32'(trig0), 32'(mtrig(0)));
    chk({tag, ".cnt0"},  32'(cnt0),  32'(mcnt[0]));
    chk({tag, ".al0"},   32'(al0),   32'(mal[0]));
    chk({tag, ".wd0"},   32'(wd0),   32'(mwd[0]));
    chk({tag, ".trig1"}, 32'(trig1), 32'(mtrig(1)));
    chk({tag, ".cnt1"},  32'(cnt1),  32'(mcnt[1]));
    chk({tag, ".al1"},   32'(al1),   32'(mal[1]));
    chk({tag, ".wd1"},   32'(wd1),   32'(mwd[1]));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_word(input int w, input logic [W-1:0] a, input logic [W-1:0] b);
    sh0[w*W +: W] = a;
    sh1[w*W +: W] = b;
  endtask

  initial begin
    int sel;
    rst_ni = 1'b0; cfg_en = 1'b0; clear = 1'b0; key_we = '0;
    sh0 = '0; sh1 = '0; probe = 1'b0; probe_valid = 1'b0;
    cyc = 0;
    model_reset();

    // Reset then idle with enable
    for (int i = 0; i < 5; i++) step("reset");
    rst_ni = 1'b1; cfg_en = 1'b1;
    for (int i = 0; i < 10; i++) step("idle");
    chk("idle_alert", 32'(al0), 32'd0);

    // Low-HW key never triggers
    set_word(0, 32'h0000_0001, 32'h0); key_we = 4'b0001;
    step("lowhw_wr");
    key_we = '0; probe = 1'b1; probe_valid = 1'b1;
    for (int i = 0; i < 20; i++) step("lowhw");
    chk("lowhw_cnt", 32'(cnt0), 32'd0);

    // High-HW key, matching probe: trigger 4 edges after write, then alert
    set_word(0, 32'hFFFF_FFFC, 32'h0000_0001); key_we = 4'b0001;
    step("hi_wr");
    key_we = '0;
    for (int i = 0; i < 3; i++) step("hi_wait");
    chk("hi_trig_early", 32'(trig0[0]), 32'd0);
    step("hi_trig_edge");
    chk("hi_trig_rise", 32'(trig0[0]), 32'd1);
    for (int i = 0; i < 20 && mal[0] == 0; i++) step("hi_match");
    chk("hi_alert", 32'(al0), 32'd1);
    chk("hi_word", 32'(wd0), 32'd0);
    chk("hi_cnt", 32'(cnt0), 32'd8);

    // Same key, mismatching probe: never alerts
    clear = 1'b1; step("clr1");
    clear = 1'b0; probe = 1'b0;
    for (int i = 0; i < 15; i++) step("mis");
    chk("mis_alert", 32'(al0), 32'd0);

    // Rewrite two edges later, mismatch after 5 matches
    probe = 1'b1;
    key_we = 4'b0001; step("rw_wr1");
    key_we = '0;      step("rw_gap");
    key_we = 4'b0001; step("rw_wr2");
    key_we = '0;
    for (int i = 0; i < 3; i++) step("rw_wait");
    chk("rw_trig_late", 32'(trig0[0]), 32'd0);
    for (int i = 0; i < 30 && mcnt[0] != 5; i++) step("rw_m");
    chk("rw_cnt5", 32'(cnt0), 32'd5);
    probe = 1'b0; step("rw_mis");
    chk("rw_cnt0", 32'(cnt0), 32'd0);
    probe = 1'b1;
    for (int i = 0; i < 7; i++) step("rw_m2");
    chk("rw_noalert", 32'(al0), 32'd0);
    step("rw_m8");
    chk("rw_alert", 32'(al0), 32'd1);

    // Multi-word selection, both HW sources
    set_word(0, 32'h0, 32'h0);
    set_word(1, 32'hFFFF_FFFF, 32'h0000_00FE);
    set_word(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_word(3, 32'hFFFF_FFFF, 32'h0000_00FE);
    clear = 1'b1; key_we = 4'b1111; step("mw_wr");
    clear = 1'b0; key_we = '0;
    for (int i = 0; i < 30 && (mal[0] == 0 || mal[1] == 0); i++) step("mw");
    chk("mw_alert1", 32'(al1), 32'd1);
    chk("mw_word1", 32'(wd1), 32'd1);
    chk("mw_word0", 32'(wd0), 32'd1);
    chk("mw_trig1", 32'(trig1), 32'b1010);

    // Clear on the same edge as a valid match
    clear = 1'b1; step("clr_match");
    chk("clr_alert", 32'(al1), 32'd0);
    chk("clr_cnt", 32'(cnt1), 32'd0);
    clear = 1'b0;
    for (int i = 0; i < 20 && mal[1] == 0; i++) step("re_alert");
    chk("re_alert", 32'(al1), 32'd1);

    // Asynchronous reset in ALERT
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_al", 32'(al1), 32'd0);
    step("rst_hold");
    rst_ni = 1'b1;

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      key_we = '0;
      for (int w = 0; w < NW; w++) begin
        if ($urandom_range(0, 7) == 0) begin
          key_we[w] = 1'b1;
          sel = $urandom_range(0, 4);
          case (sel)
            0: set_word(w, 32'hFFFF_FFFF, 32'h0000_00FE);
            1: set_word(w, 32'hFFFF_FFFC, 32'h0000_0001);
            2: set_word(w, 32'h0000_0001, 32'h0);
            3: set_word(w, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            default: set_word(w, W'($urandom), W'($urandom));
          endcase
        end
      end
      probe       = ($urandom_range(0, 7) != 0);
      probe_valid = ($urandom_range(0, 3) != 0);
      cfg_en      = ($urandom_range(0, 15) != 0);
      clear       = ($urandom_range(0, 31) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
